// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jalr resolution: checks IF-stage predictions, raises a registered
// flush with the corrected PC, feeds back predictor-training strobes, counts events.
module branch_resolve_unit #(
  parameter int unsigned SHADOW_CYCLES = 0,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_ex,
  input  logic                 PL_stall,
  input  logic                 B_type_ex,
  input  logic                 beq_ex,
  input  logic                 bne_ex,
  input  logic                 blt_ex,
  input  logic                 bge_ex,
  input  logic                 bltu_ex,
  input  logic                 bgeu_ex,
  input  logic                 jalr_ex,
  input  logic [31:0]          pc_ex,
  input  logic [31:0]          imme_ex,
  input  logic [31:0]          rs1_data_ex,
  input  logic [31:0]          rs2_data_ex,
  input  logic                 B_type_prediction_result_ex,
  input  logic [31:0]          jalr_pc_prediction_ex,
  output logic                 PL_flush,
  output logic [31:0]          pc_rollback,
  output logic                 B_type_branch_failed,
  output logic                 beq_branch_failed,
  output logic                 bne_branch_failed,
  output logic                 blt_branch_failed,
  output logic                 bge_branch_failed,
  output logic                 bltu_branch_failed,
  output logic                 bgeu_branch_failed,
  output logic [31:0]          pc_branch_filled,
  output logic                 B_type_prediction_result_branch_failed,
  output logic [CNT_WIDTH-1:0] resolved_cnt,
  output logic [CNT_WIDTH-1:0] mispredict_cnt
);

  localparam int unsigned SH_W = 3;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FLUSH  = 2'd1,
    S_SHADOW = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [SH_W-1:0] shadow_cnt;
  logic [SH_W-1:0] shadow_cnt_nxt;

  logic        op_eq;
  logic        op_lt_s;
  logic        op_lt_u;
  logic        b_taken;
  logic        b_mispredict;
  logic [31:0] b_target;
  logic [31:0] b_fallthru;
  logic [31:0] jalr_target;
  logic        jalr_mispredict;
  logic        mispredict;
  logic [31:0] rollback;
  logic        resolve_en;
  logic        fire;
  logic        fire_b;

  // Branch condition evaluation on the forwarded operands
  assign op_eq   = (rs1_data_ex == rs2_data_ex);
  assign op_lt_s = ($signed(rs1_data_ex) < $signed(rs2_data_ex));
  assign op_lt_u = (rs1_data_ex < rs2_data_ex);

  assign b_taken = (beq_ex  &  op_eq)   | (bne_ex  & ~op_eq)   |
                   (blt_ex  &  op_lt_s) | (bge_ex  & ~op_lt_s) |
                   (bltu_ex &  op_lt_u) | (bgeu_ex & ~op_lt_u);

  assign b_target     = pc_ex + imme_ex;
  assign b_fallthru   = pc_ex + 32'd4;
  assign b_mispredict = (b_taken != B_type_prediction_result_ex);

  assign jalr_target     = (rs1_data_ex + imme_ex) & 32'hFFFF_FFFE;
  assign jalr_mispredict = (jalr_target != jalr_pc_prediction_ex);

  // B-type wins if decode ever flags both kinds at once
  assign mispredict = B_type_ex ? b_mispredict : (jalr_ex & jalr_mispredict);
  assign rollback   = B_type_ex ? (b_taken ? b_target : b_fallthru) : jalr_target;

  assign resolve_en = valid_ex & ~PL_stall & (state == S_IDLE) & (B_type_ex | jalr_ex);
  assign fire       = resolve_en & mispredict;
  assign fire_b     = fire & B_type_ex;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      shadow_cnt <= '0;
    end else begin
      state      <= state_nxt;
      shadow_cnt <= shadow_cnt_nxt;
    end
  end

  // Flush lasts one cycle unconditionally; the shadow drains only on advancing cycles
  always_comb begin
    state_nxt      = state;
    shadow_cnt_nxt = shadow_cnt;
    case (state)
      S_IDLE: begin
        if (fire) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (SHADOW_CYCLES > 0) begin
          state_nxt      = S_SHADOW;
          shadow_cnt_nxt = SH_W'(SHADOW_CYCLES);
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_SHADOW: begin
        if (!PL_stall) begin
          shadow_cnt_nxt = shadow_cnt - SH_W'(1);
          if (shadow_cnt <= SH_W'(1)) state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt      = S_IDLE;
        shadow_cnt_nxt = '0;
      end
    endcase
  end

  // Registered flush and predictor feedback; PC payloads hold between pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      PL_flush                               <= 1'b0;
      pc_rollback                            <= '0;
      B_type_branch_failed                   <= 1'b0;
      beq_branch_failed                      <= 1'b0;
      bne_branch_failed                      <= 1'b0;
      blt_branch_failed                      <= 1'b0;
      bge_branch_failed                      <= 1'b0;
      bltu_branch_failed                     <= 1'b0;
      bgeu_branch_failed                     <= 1'b0;
      pc_branch_filled                       <= '0;
      B_type_prediction_result_branch_failed <= 1'b0;
    end else begin
      PL_flush             <= fire;
      B_type_branch_failed <= fire_b;
      beq_branch_failed    <= fire_b & beq_ex;
      bne_branch_failed    <= fire_b & bne_ex;
      blt_branch_failed    <= fire_b & blt_ex;
      bge_branch_failed    <= fire_b & bge_ex;
      bltu_branch_failed   <= fire_b & bltu_ex;
      bgeu_branch_failed   <= fire_b & bgeu_ex;
      if (fire) pc_rollback <= rollback;
      if (fire_b) begin
        pc_branch_filled                       <= pc_ex;
        B_type_prediction_result_branch_failed <= B_type_prediction_result_ex;
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resolved_cnt   <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (resolve_en && (resolved_cnt != CNT_MAX))
        resolved_cnt <= resolved_cnt + CNT_WIDTH'(1);
      if (fire && (mispredict_cnt != CNT_MAX))
        mispredict_cnt <= mispredict_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench: two instances (no shadow / 16-bit counters, 2-cycle shadow / 4-bit counters)
// share stimulus, each gated by its own valid; expected pulses are queued per instance.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst_n;
  logic        valid_a, valid_b, stall;
  logic        bt, k_beq, k_bne, k_blt, k_bge, k_bltu, k_bgeu, k_jalr;
  logic [31:0] pc, imm, rs1, rs2, jp;
  logic        pr;

  logic        a_flush, a_bf, a_pr, b_flush, b_bf, b_pr;
  logic [31:0] a_rb, a_pcf, b_rb, b_pcf;
  logic [5:0]  a_cls, b_cls;
  logic [15:0] a_res, a_mis;
  logic [3:0]  b_res, b_mis;

  branch_resolve_unit #(.SHADOW_CYCLES(0), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .valid_ex(valid_a), .PL_stall(stall),
    .B_type_ex(bt), .beq_ex(k_beq), .bne_ex(k_bne), .blt_ex(k_blt), .bge_ex(k_bge),
    .bltu_ex(k_bltu), .bgeu_ex(k_bgeu), .jalr_ex(k_jalr),
    .pc_ex(pc), .imme_ex(imm), .rs1_data_ex(rs1), .rs2_data_ex(rs2),
    .B_type_prediction_result_ex(pr), .jalr_pc_prediction_ex(jp),
    .PL_flush(a_flush), .pc_rollback(a_rb), .B_type_branch_failed(a_bf),
    .beq_branch_failed(a_cls[0]), .bne_branch_failed(a_cls[1]), .blt_branch_failed(a_cls[2]),
    .bge_branch_failed(a_cls[3]), .bltu_branch_failed(a_cls[4]), .bgeu_branch_failed(a_cls[5]),
    .pc_branch_filled(a_pcf), .B_type_prediction_result_branch_failed(a_pr),
    .resolved_cnt(a_res), .mispredict_cnt(a_mis)
  );

  branch_resolve_unit #(.SHADOW_CYCLES(2), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid_ex(valid_b), .PL_stall(stall),
    .B_type_ex(bt), .beq_ex(k_beq), .bne_ex(k_bne), .blt_ex(k_blt), .bge_ex(k_bge),
    .bltu_ex(k_bltu), .bgeu_ex(k_bgeu), .jalr_ex(k_jalr),
    .pc_ex(pc), .imme_ex(imm), .rs1_data_ex(rs1), .rs2_data_ex(rs2),
    .B_type_prediction_result_ex(pr), .jalr_pc_prediction_ex(jp),
    .PL_flush(b_flush), .pc_rollback(b_rb), .B_type_branch_failed(b_bf),
    .beq_branch_failed(b_cls[0]), .bne_branch_failed(b_cls[1]), .blt_branch_failed(b_cls[2]),
    .bge_branch_failed(b_cls[3]), .bltu_branch_failed(b_cls[4]), .bgeu_branch_failed(b_cls[5]),
    .pc_branch_filled(b_pcf), .B_type_prediction_result_branch_failed(b_pr),
    .resolved_cnt(b_res), .mispredict_cnt(b_mis)
  );

  typedef struct {
    int          cyc;
    logic [31:0] rb;
    logic        bf;
    logic [5:0]  cls;
    logic [31:0] pcf;
    logic        pr;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Kinds: 0 none, 1 beq, 2 bne, 3 blt, 4 bge, 5 bltu, 6 bgeu, 7 jalr, 8 beq+jalr
  task automatic push(input int to_a, input int to_b, input logic [31:0] rb, input int k,
                      input logic [31:0] pcf, input int p);
    exp_t e;
    e.cyc = cyc + 1;
    e.rb  = rb;
    e.bf  = (k >= 1 && k <= 6);
    e.cls = (k >= 1 && k <= 6) ? 6'(1 << (k - 1)) : 6'd0;
    e.pcf = pcf;
    e.pr  = (p != 0);
    if (to_a != 0) qa.push_back(e);
    if (to_b != 0) qb.push_back(e);
  endtask

  task automatic drive(input int va, input int vb, input int st, input int k,
                       input logic [31:0] p, input logic [31:0] im, input logic [31:0] r1,
                       input logic [31:0] r2, input int prd, input logic [31:0] jpv);
    valid_a = (va != 0);
    valid_b = (vb != 0);
    stall   = (st != 0);
    bt      = (k >= 1 && k <= 6) || (k == 8);
    k_beq   = (k == 1) || (k == 8);
    k_bne   = (k == 2);
    k_blt   = (k == 3);
    k_bge   = (k == 4);
    k_bltu  = (k == 5);
    k_bgeu  = (k == 6);
    k_jalr  = (k >= 7);
    pc = p; imm = im; rs1 = r1; rs2 = r2; pr = (prd != 0); jp = jpv;
    @(negedge clk);
  endtask

  task automatic bubble(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Pops an expectation whenever an instance pulses; flags late or unexpected pulses
  task automatic mon(input int which, input logic fl, input logic [31:0] rb, input logic bf,
                     input logic [5:0] cls, input logic [31:0] pcf, input logic p);
    exp_t  e;
    string tag;
    int    sz;
    tag = (which == 0) ? "a" : "b";
    sz  = (which == 0) ? qa.size() : qb.size();
    if ((fl | bf | (|cls)) === 1'b1) begin
      if (sz == 0) begin
        n_chk++;
        $display("FAIL %s_unexpected_pulse: got flush=%b rb=%h failed=%b%b want no pulse",
                 tag, fl, rb, bf, cls);
      end else begin
        e = (which == 0) ? qa.pop_front() : qb.pop_front();
        chk({tag, "_pulse_cycle"}, 32'(cyc), 32'(e.cyc));
        chk({tag, "_flush"}, 32'(fl), 32'd1);
        chk({tag, "_rollback"}, rb, e.rb);
        chk({tag, "_failed_strobes"}, 32'({bf, cls}), 32'({e.bf, e.cls}));
        chk({tag, "_pc_filled"}, pcf, e.pcf);
        if (e.bf) chk({tag, "_pred_failed"}, 32'(p), 32'(e.pr));
      end
    end else if (sz != 0) begin
      e = (which == 0) ? qa[0] : qb[0];
      if (e.cyc < cyc) begin
        chk({tag, "_missing_pulse_cycle"}, 32'(cyc), 32'(e.cyc));
        if (which == 0) void'(qa.pop_front());
        else void'(qb.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_flush, a_rb, a_bf, a_cls, a_pcf, a_pr);
    mon(1, b_flush, b_rb, b_bf, b_cls, b_pcf, b_pr);
  end

  initial begin
    rst_n = 1'b0;
    bubble(2);
    chk("a_rst_flush", 32'(a_flush), 0);
    chk("a_rst_rollback", a_rb, 0);
    chk("a_rst_pc_filled", a_pcf, 0);
    chk("a_rst_strobes", 32'({a_bf, a_cls, a_pr}), 0);
    chk("a_rst_resolved", 32'(a_res), 0);
    chk("a_rst_mispredict", 32'(a_mis), 0);
    chk("b_rst_counters", 32'({b_res, b_mis}), 0);
    rst_n = 1'b1;
    bubble(1);

    // Instance A, no shadow
    push(1, 0, 'h120, 1, 'h100, 0);
    drive(1, 0, 0, 1, 'h100, 'h20, 5, 5, 0, 0);
    drive(1, 0, 0, 2, 'h180, 'h8, 3, 3, 1, 0);
    bubble(1);
    chk("a_resolved_1", 32'(a_res), 1);
    chk("a_mispredict_1", 32'(a_mis), 1);
    drive(1, 0, 0, 3, 'h140, 'h10, 'hFFFF_FFFF, 1, 1, 0);
    push(1, 0, 'h204, 5, 'h200, 1);
    drive(1, 0, 0, 5, 'h200, 'h40, 'hFFFF_FFFF, 1, 1, 0);
    bubble(1);
    drive(1, 0, 0, 7, 'h300, 0, 'h203, 0, 0, 'h202);
    push(1, 0, 'h202, 7, 'h200, 0);
    drive(1, 0, 0, 7, 'h300, 0, 'h203, 0, 0, 'h204);
    bubble(1);
    drive(1, 0, 0, 7, 'h310, 'hFFFF_FFFD, 'h1000, 0, 0, 'hFFC);
    push(1, 0, 'h504, 2, 'h500, 1);
    drive(1, 0, 0, 2, 'h500, 'h80, 7, 7, 1, 0);
    bubble(1);
    push(1, 0, 'h10, 4, 'hFFFF_FFF0, 0);
    drive(1, 0, 0, 4, 'hFFFF_FFF0, 'h20, 1, 'hFFFF_FFFF, 0, 0);
    bubble(1);
    drive(1, 0, 0, 6, 'h520, 'h20, 1, 'hFFFF_FFFF, 0, 0);
    push(1, 0, 'h0, 3, 'hFFFF_FFFC, 1);
    drive(1, 0, 0, 3, 'hFFFF_FFFC, 'h100, 4, 4, 1, 0);
    bubble(1);
    drive(1, 0, 0, 8, 'h540, 'h40, 1, 2, 0, 'h1234_5678);
    drive(1, 0, 1, 1, 'h560, 'h20, 5, 5, 0, 0);
    drive(0, 0, 0, 1, 'h580, 'h20, 5, 5, 0, 0);
    chk("a_resolved_11", 32'(a_res), 11);
    chk("a_mispredict_6", 32'(a_mis), 6);
    push(1, 0, 'h60C, 1, 'h600, 0);
    drive(1, 0, 0, 1, 'h600, 'hC, 6, 6, 0, 0);
    drive(1, 0, 1, 1, 'h620, 'h20, 5, 5, 0, 0);
    push(1, 0, 'h704, 6, 'h700, 1);
    drive(1, 0, 0, 6, 'h700, 4, 0, 1, 1, 0);
    bubble(2);
    chk("a_rollback_hold", a_rb, 'h704);
    chk("a_resolved_13", 32'(a_res), 13);
    chk("a_mispredict_8", 32'(a_mis), 8);

    // Instance B, two-cycle shadow with one stalled shadow cycle
    push(0, 1, 'h308, 1, 'h300, 0);
    drive(0, 1, 0, 1, 'h300, 8, 5, 5, 0, 0);
    drive(0, 1, 0, 2, 'h380, 8, 3, 3, 1, 0);
    drive(0, 1, 1, 2, 'h380, 8, 3, 3, 1, 0);
    drive(0, 1, 0, 2, 'h380, 8, 3, 3, 1, 0);
    drive(0, 1, 0, 2, 'h380, 8, 3, 3, 1, 0);
    chk("b_shadow_resolved", 32'(b_res), 1);
    chk("b_shadow_mispredict", 32'(b_mis), 1);
    push(0, 1, 'h410, 1, 'h400, 0);
    drive(0, 1, 0, 1, 'h400, 'h10, 9, 9, 0, 0);
    bubble(3);
    for (int i = 0; i < 17; i++) begin
      push(0, 1, 32'('h1008 + i * 16), 1, 32'('h1000 + i * 16), 0);
      drive(0, 1, 0, 1, 32'('h1000 + i * 16), 8, 32'(i), 32'(i), 0, 0);
      bubble(3);
    end
    chk("b_resolved_sat", 32'(b_res), 15);
    chk("b_mispredict_sat", 32'(b_mis), 15);

    // Reset during the flush cycle on both instances
    push(1, 1, 'h810, 1, 'h800, 0);
    drive(1, 1, 0, 1, 'h800, 'h10, 5, 5, 0, 0);
    rst_n = 1'b0;
    drive(1, 1, 0, 1, 'h840, 'h10, 5, 5, 0, 0);
    chk("a_midrst_flush", 32'(a_flush), 0);
    chk("a_midrst_rollback", a_rb, 0);
    chk("a_midrst_pc_filled", a_pcf, 0);
    chk("a_midrst_strobes", 32'({a_bf, a_cls, a_pr}), 0);
    chk("a_midrst_counters", 32'({a_res, a_mis}), 0);
    chk("b_midrst_flush", 32'(b_flush), 0);
    chk("b_midrst_rollback", b_rb, 0);
    chk("b_midrst_counters", 32'({b_res, b_mis}), 0);
    rst_n = 1'b1;
    push(1, 1, 'h904, 2, 'h900, 1);
    drive(1, 1, 0, 2, 'h900, 'h10, 2, 2, 1, 0);
    bubble(4);
    chk("a_post_rst_counters", 32'({a_res, a_mis}), 32'h0001_0001);
    chk("b_post_rst_counters", 32'({b_res, b_mis}), 32'h11);
    chk("a_queue_drained", 32'(qa.size()), 0);
    chk("b_queue_drained", 32'(qb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
